// File: rtl/system_store_burst_pkg.sv
// Shared constants and types for the register-file read-burst block.
package system_store_burst_pkg;

  localparam int unsigned VEC_DEPTH = 32;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned VEC_W     = VEC_DEPTH * WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One output beat as seen on the out_* port group.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/system_index_vec.sv
// Selects one word from a flattened register file; entry 0 sits at the MSBs.
module system_index_vec
  import system_store_burst_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic [ADDR_W-1:0] idx,
  output logic [WORD_W-1:0] word_c
);

  logic [WORD_W-1:0] words [VEC_DEPTH];

  // Unflatten the vector and pick the addressed entry.
  always_comb begin
    for (int k = 0; k < VEC_DEPTH; k++) begin
      words[k] = vec[(VEC_DEPTH-1-k)*WORD_W +: WORD_W];
    end
    word_c = words[idx];
  end

endmodule

// File: rtl/system_store_burst.sv
// Snapshots a register file on request and streams a burst of consecutive
// entries (wrapping 31 -> 0) over a valid/ready output port.
module system_store_burst
  import system_store_burst_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WORD_W = 16
) (
  input  logic                      system1000,
  input  logic                      system1000_rstn,
  input  logic [DEPTH*WORD_W-1:0]   regs_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_addr_i,
  input  logic [ADDR_W-1:0]         req_len_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WORD_W-1:0]         out_data_o,
  output logic [ADDR_W-1:0]         out_addr_o,
  output logic                      out_last_o,
  output logic                      busy_o
);

  state_e                    state_q, state_d;
  logic [DEPTH*WORD_W-1:0]   snap_q;
  logic [ADDR_W-1:0]         ptr_q;
  logic [ADDR_W-1:0]         rem_q;
  logic [WORD_W-1:0]         data_q;
  logic                      last_q;

  logic                      accept_c;
  logic                      beat_c;
  logic [ADDR_W-1:0]         ptr_nxt_c;
  logic [DEPTH*WORD_W-1:0]   sel_vec_c;
  logic [ADDR_W-1:0]         sel_idx_c;
  logic [WORD_W-1:0]         sel_word_c;

  // Handshake qualifiers and the word lookup feeding the output data register.
  always_comb begin
    accept_c  = req_valid_i && (state_q == IDLE);
    beat_c    = out_ready_i && (state_q == RUN);
    ptr_nxt_c = ADDR_W'(ptr_q + ADDR_W'(1));
    // On accept the live input is the snapshot-to-be; afterwards read ahead.
    sel_vec_c = accept_c ? regs_i     : snap_q;
    sel_idx_c = accept_c ? req_addr_i : ptr_nxt_c;
  end

  system_index_vec u_index_vec (
    .vec    (sel_vec_c),
    .idx    (sel_idx_c),
    .word_c (sel_word_c)
  );

  // State register.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = RUN;
      RUN:  if (out_ready_i && (rem_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst datapath: snapshot, pointer, remaining count and output word.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      snap_q <= '0;
      ptr_q  <= '0;
      rem_q  <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (accept_c) begin
      snap_q <= regs_i;
      ptr_q  <= req_addr_i;
      rem_q  <= req_len_i;
      data_q <= sel_word_c;
      last_q <= (req_len_i == '0);
    end else if (beat_c) begin
      if (rem_q != '0) begin
        ptr_q  <= ptr_nxt_c;
        rem_q  <= ADDR_W'(rem_q - ADDR_W'(1));
        data_q <= sel_word_c;
        last_q <= (rem_q == ADDR_W'(1));
      end else begin
        last_q <= 1'b0;
      end
    end
  end

  // Output decode straight from registers.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    busy_o      = (state_q == RUN);
    out_valid_o = (state_q == RUN);
    out_data_o  = data_q;
    out_addr_o  = ptr_q;
    out_last_o  = last_q;
  end

endmodule

// File: tb/tb_system_store_burst.sv
// Scoreboard bench for system_store_burst: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output word.
module tb_system_store_burst;
  import system_store_burst_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [511:0] regs;
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_addr;
  logic [4:0]   req_len;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [4:0]   out_addr;
  logic         out_last;
  logic         busy;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  bit    toggle_mode = 1'b0;
  bit    after_last  = 1'b0;
  logic [4:0] last_addr = '0;
  logic [15:0] model [32];

  system_store_burst dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .regs_i          (regs),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_len_i       (req_len),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_data_o      (out_data),
    .out_addr_o      (out_addr),
    .out_last_o      (out_last),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_regs();
    for (int k = 0; k < 32; k++) regs[(31-k)*16 +: 16] = model[k];
  endtask

  task automatic push_beat(input logic [4:0] a, input logic [15:0] d, input logic l);
    beat_t b;
    b.addr = a; b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic push_burst(input int a, input int len);
    for (int i = 0; i <= len; i++) begin
      push_beat(5'((a + i) % 32), model[(a + i) % 32], (i == len));
    end
  endtask

  // Present a request, wait (bounded) for acceptance, then check 1-cycle latency.
  task automatic issue(input logic [4:0] a, input logic [4:0] l);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = l;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready never seen for addr %0d", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("first_word_latency", out_valid, 1'b1);
  endtask

  // Count valid cycles until the burst drains; exp_cycles < 0 skips the count check.
  task automatic wait_done(input string name, input int exp_cycles);
    int cnt;
    bit ok;
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!out_valid && exp_q.size() == 0) begin ok = 1'b1; break; end
      if (out_valid) cnt++;
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: burst did not drain, %0d beats left", name, exp_q.size());
    end
    if (exp_cycles >= 0) chk({name, "_cycles"}, 32'(cnt), 32'(exp_cycles));
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Consumer readiness: always ready, or toggling every cycle.
  always @(posedge clk) begin
    #1;
    if (toggle_mode) out_ready = ~out_ready;
    else             out_ready = 1'b1;
  end

  // Monitor: compare every accepted beat and every stalled word against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        chk("ready_after_last", req_ready, 1'b1);
        chk("idle_valid_low", out_valid, 1'b0);
        chk("idle_last_low", out_last, 1'b0);
        chk("idle_addr_hold", out_addr, last_addr);
        after_last = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: addr %0h data %0h", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", out_addr, e.addr);
          chk("beat_data", out_data, e.data);
          chk("beat_last", out_last, e.last);
          if (e.last) begin
            after_last = 1'b1;
            last_addr  = e.addr;
          end
        end
      end else if (out_valid && exp_q.size() != 0) begin
        chk("stall_addr", out_addr, exp_q[0].addr);
        chk("stall_data", out_data, exp_q[0].data);
        chk("stall_last", out_last, exp_q[0].last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) model[k] = 16'h1000 + 16'(k);
    load_regs();
    req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_addr", out_addr, 5'd0);
    chk("rst_last", out_last, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic burst addr=3 len=2.
    push_beat(5'd3, 16'h1003, 1'b0);
    push_beat(5'd4, 16'h1004, 1'b0);
    push_beat(5'd5, 16'h1005, 1'b1);
    issue(5'd3, 5'd2);
    chk("busy_in_run", busy, 1'b1);
    wait_done("basic", 3);

    // Wrap 30 -> 1.
    push_beat(5'd30, 16'h101E, 1'b0);
    push_beat(5'd31, 16'h101F, 1'b0);
    push_beat(5'd0,  16'h1000, 1'b0);
    push_beat(5'd1,  16'h1001, 1'b1);
    issue(5'd30, 5'd3);
    wait_done("wrap", 4);

    // Backpressure with a request presented mid-burst that must be ignored.
    toggle_mode = 1'b1;
    push_beat(5'd0, 16'h1000, 1'b0);
    push_beat(5'd1, 16'h1001, 1'b1);
    issue(5'd0, 5'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 5'd9; req_len = 5'd0;
    @(negedge clk);
    chk("run_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done("backpressure", -1);
    toggle_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Snapshot: overwrite entry 5 right after accept.
    push_beat(5'd5, 16'h1005, 1'b1);
    issue(5'd5, 5'd0);
    regs[(31-5)*16 +: 16] = 16'h8000;
    wait_done("snapshot", 1);
    load_regs();

    // Full 32-word burst starting mid-file.
    push_burst(17, 31);
    issue(5'd17, 5'd31);
    wait_done("full32", 32);

    // Reset during the second beat of a 32-word burst.
    push_beat(5'd0, 16'h1000, 1'b0);
    issue(5'd0, 5'd31);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", out_addr, 5'd0);
    chk("midrst_data", out_data, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", req_ready, 1'b1);
    chk("postrst_valid", out_valid, 1'b0);
    chk("postrst_queue", 32'(exp_q.size()), 32'd0);
    push_beat(5'd7, 16'h1007, 1'b1);
    issue(5'd7, 5'd0);
    wait_done("postrst", 1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
